// File: rtl/reg_bank.sv
// reg_bank: parametrised register file with load / increment / shift-left,
// a registered carry flag and one combinational read port driving a
// tri-state system bus.
//
// Optional feature macro: REG_BANK_BYPASS_EN
//   When defined, a load whose waddr equals raddr is forwarded to the read
//   port (Q/Qout/zero/bus) before the clock edge. Increment and shift are
//   never forwarded, and forwarding is suppressed while rst_n is low.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   data     in   WIDTH  load data
//   waddr    in   AW     register targeted by op
//   op       in   2      00 hold, 01 load, 10 increment, 11 shift left
//   sin      in   1      serial bit shifted into the LSB on op=11
//   raddr    in   AW     read-port select
//   outctrl  in   1      1 drives bus, 0 releases it (high-Z)
//   Q        out  WIDTH  contents of register raddr (combinational)
//   Qout     out  WIDTH  ~Q
//   bus      out  WIDTH  Q when outctrl=1, else all-Z
//   carry    out  1      registered carry / shift-out flag
//   zero     out  1      Q == 0 (combinational)
module reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [1:0]                 op,
  input  logic                       sin,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  input  logic                       outctrl,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Qout,
  output wire  [WIDTH-1:0]           bus,
  output logic                       carry,
  output logic                       zero
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q;
  logic             carry_d;

  logic [WIDTH-1:0] cur_c;
  logic [WIDTH:0]   inc_c;
  logic [WIDTH-1:0] rd_c;

  // Operand for the write port and its WIDTH+1-bit increment.
  assign cur_c = regs_q[waddr];
  assign inc_c = {1'b0, cur_c} + (WIDTH+1)'(1);

  // Next-state: only the addressed register and carry may change.
  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    case (op)
      OP_HOLD: begin
        carry_d = carry_q;
      end
      OP_LOAD: begin
        regs_d[waddr] = data;
        carry_d       = 1'b0;
      end
      OP_INC: begin
        regs_d[waddr] = inc_c[WIDTH-1:0];
        carry_d       = inc_c[WIDTH];
      end
      OP_SHIFT: begin
        regs_d[waddr] = {cur_c[WIDTH-2:0], sin};
        carry_d       = cur_c[WIDTH-1];
      end
      default: begin
        carry_d = carry_q;
      end
    endcase
  end

  // State registers; reset clears everything without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= regs_d[i];
      end
      carry_q <= carry_d;
    end
  end

  // Read port, optionally forwarding a same-address load.
`ifdef REG_BANK_BYPASS_EN
  logic fwd_c;
  assign fwd_c = rst_n && (op == OP_LOAD) && (waddr == raddr);
  assign rd_c  = fwd_c ? data : regs_q[raddr];
`else
  assign rd_c  = regs_q[raddr];
`endif

  assign Q     = rd_c;
  assign Qout  = ~rd_c;
  assign zero  = (rd_c == '0);
  assign carry = carry_q;

  // Bus is a pure function of outctrl and Q.
  assign bus = outctrl ? rd_c : {WIDTH{1'bz}};

  // Keeps AW referenced for builds that do not otherwise use it.
  logic unused_aw_c;
  assign unused_aw_c = (AW == 0);

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: default 8x4 instance plus a 16x8 instance. A
// behavioural model (integer arithmetic on arrays) is checked on every
// falling edge; directed steps add hand-computed literal checks.
// The bus nets are pulled high, so a released bus reads all-ones.
module tb_reg_bank;

  logic clk;
  logic rst_n;

  // 8-bit / 4-deep instance
  logic [7:0]  data_a;
  logic [1:0]  waddr_a;
  logic [1:0]  op_a;
  logic        sin_a;
  logic [1:0]  raddr_a;
  logic        outctrl_a;
  logic [7:0]  q_a;
  logic [7:0]  qout_a;
  tri1  [7:0]  bus_a;
  logic        carry_a;
  logic        zero_a;

  // 16-bit / 8-deep instance
  logic [15:0] data_b;
  logic [2:0]  waddr_b;
  logic [1:0]  op_b;
  logic        sin_b;
  logic [2:0]  raddr_b;
  logic        outctrl_b;
  logic [15:0] q_b;
  logic [15:0] qout_b;
  tri1  [15:0] bus_b;
  logic        carry_b;
  logic        zero_b;

  int vectors;
  int miscompares;

  reg_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .data(data_a), .waddr(waddr_a), .op(op_a),
    .sin(sin_a), .raddr(raddr_a), .outctrl(outctrl_a), .Q(q_a),
    .Qout(qout_a), .bus(bus_a), .carry(carry_a), .zero(zero_a)
  );

  reg_bank #(.WIDTH(16), .DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .data(data_b), .waddr(waddr_b), .op(op_b),
    .sin(sin_b), .raddr(raddr_b), .outctrl(outctrl_b), .Q(q_b),
    .Qout(qout_b), .bus(bus_b), .carry(carry_b), .zero(zero_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  int unsigned ma [4];
  int unsigned mb [8];
  bit          ca;
  bit          cb;

  initial begin
    for (int i = 0; i < 4; i++) ma[i] = 0;
    for (int i = 0; i < 8; i++) mb[i] = 0;
    ca = 0;
    cb = 0;
  end

  // One operation on a w-bit value using plain arithmetic.
  function automatic void model_op(input int w, input logic [1:0] o,
                                   input int unsigned v, input int unsigned d,
                                   input logic s, input bit c_in,
                                   output int unsigned v_out, output bit c_out);
    longint unsigned lim;
    lim   = longint'(1) << w;
    v_out = v;
    c_out = c_in;
    case (o)
      2'd1: begin v_out = d; c_out = 0; end
      2'd2: begin
        c_out = (longint'(v) + 1 == lim);
        v_out = int'((longint'(v) + 1) % lim);
      end
      2'd3: begin
        c_out = (longint'(v) >= lim / 2);
        v_out = int'((longint'(v) * 2 + longint'(s)) % lim);
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    int unsigned nv;
    bit          nc;
    if (rst_n === 1'b1) begin
      model_op(8, op_a, ma[waddr_a], data_a, sin_a, ca, nv, nc);
      ma[waddr_a] = nv;
      ca = nc;
      model_op(16, op_b, mb[waddr_b], data_b, sin_b, cb, nv, nc);
      mb[waddr_b] = nv;
      cb = nc;
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 4; i++) ma[i] = 0;
    for (int i = 0; i < 8; i++) mb[i] = 0;
    ca = 0;
    cb = 0;
  end

  function automatic int unsigned exp_q_a();
`ifdef REG_BANK_BYPASS_EN
    if (rst_n === 1'b1 && op_a == 2'd1 && waddr_a == raddr_a) return int'(data_a);
`endif
    return ma[raddr_a];
  endfunction

  function automatic int unsigned exp_q_b();
`ifdef REG_BANK_BYPASS_EN
    if (rst_n === 1'b1 && op_b == 2'd1 && waddr_b == raddr_b) return int'(data_b);
`endif
    return mb[raddr_b];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int unsigned ea;
    int unsigned eb;
    ea = exp_q_a();
    eb = exp_q_b();
    check("a_q",     32'(q_a),     ea);
    check("a_qout",  32'(qout_a),  ea ^ 32'hFF);
    check("a_zero",  32'(zero_a),  32'(ea == 0));
    check("a_carry", 32'(carry_a), 32'(ca));
    check("a_bus",   32'(bus_a),   outctrl_a ? ea : 32'hFF);
    check("b_q",     32'(q_b),     eb);
    check("b_qout",  32'(qout_b),  eb ^ 32'hFFFF);
    check("b_zero",  32'(zero_b),  32'(eb == 0));
    check("b_carry", 32'(carry_b), 32'(cb));
    check("b_bus",   32'(bus_b),   outctrl_b ? eb : 32'hFFFF);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    data_a    = '0; waddr_a = '0; op_a = '0; sin_a = 1'b0; raddr_a = '0; outctrl_a = 1'b1;
    data_b    = '0; waddr_b = '0; op_b = '0; sin_b = 1'b0; raddr_b = '0; outctrl_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load / readback
    op_a = 2'd1; waddr_a = 2'd2; data_a = 8'hA5; raddr_a = 2'd2;
    tick();
    op_a = 2'd0;
    check("ld_q",     32'(q_a),     32'hA5);
    check("ld_qout",  32'(qout_a),  32'h5A);
    check("ld_zero",  32'(zero_a),  32'd0);
    check("ld_carry", 32'(carry_a), 32'd0);
    raddr_a = 2'd0; #1 check("ld_r0", 32'(q_a), 32'h00);
    raddr_a = 2'd1; #1 check("ld_r1", 32'(q_a), 32'h00);
    raddr_a = 2'd3; #1 check("ld_r3", 32'(q_a), 32'h00);
    tick();

    // Increment wrap
    op_a = 2'd1; waddr_a = 2'd1; data_a = 8'hFE; raddr_a = 2'd1;
    tick();
    op_a = 2'd2;
    tick();
    check("inc1_q",     32'(q_a),     32'hFF);
    check("inc1_carry", 32'(carry_a), 32'd0);
    tick();
    check("inc2_q",     32'(q_a),     32'h00);
    check("inc2_carry", 32'(carry_a), 32'd1);
    check("inc2_zero",  32'(zero_a),  32'd1);
    op_a = 2'd0;
    tick();
    check("hold_carry", 32'(carry_a), 32'd1);

    // Shift left
    op_a = 2'd1; waddr_a = 2'd3; data_a = 8'h81; raddr_a = 2'd3;
    tick();
    op_a = 2'd3; sin_a = 1'b1;
    tick();
    check("sh1_q",     32'(q_a),     32'h03);
    check("sh1_carry", 32'(carry_a), 32'd1);
    sin_a = 1'b0;
    tick();
    check("sh2_q",     32'(q_a),     32'h06);
    check("sh2_carry", 32'(carry_a), 32'd0);
    op_a = 2'd0;
    tick();

    // Same-address load
    op_a = 2'd1; waddr_a = 2'd0; data_a = 8'h11; raddr_a = 2'd0;
    tick();
    data_a = 8'h3C;
    #1;
`ifdef REG_BANK_BYPASS_EN
    check("same_pre", 32'(q_a), 32'h3C);
`else
    check("same_pre", 32'(q_a), 32'h11);
`endif
    tick();
    op_a = 2'd0;
    check("same_post", 32'(q_a), 32'h3C);

    // Bus release
    outctrl_a = 1'b0;
    #1 check("bus_rel", 32'(bus_a), 32'hFF);
    outctrl_a = 1'b1;
    tick();

    // Set carry=1 then reset mid-cycle with a load pending
    op_a = 2'd1; waddr_a = 2'd1; data_a = 8'hFF;
    tick();
    op_a = 2'd2;
    tick();
    op_a = 2'd1; waddr_a = 2'd2; data_a = 8'h77; raddr_a = 2'd3;
    check("pre_rst_carry", 32'(carry_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_q",     32'(q_a),     32'h00);
    check("rst_qout",  32'(qout_a),  32'hFF);
    check("rst_zero",  32'(zero_a),  32'd1);
    check("rst_carry", 32'(carry_a), 32'd0);
    check("rst_bus",   32'(bus_a),   32'h00);
    tick();
    outctrl_a = 1'b0;
    #1 check("rst_bus_rel", 32'(bus_a), 32'hFF);
    outctrl_a = 1'b1;
    raddr_a = 2'd2;
    rst_n = 1'b1;
    tick();
    op_a = 2'd0;
    check("post_rst_load", 32'(q_a), 32'h77);
    raddr_a = 2'd3;
    #1 check("post_rst_r3", 32'(q_a), 32'h00);
    tick();

    // 16-bit / 8-deep instance
    op_b = 2'd1; waddr_b = 3'd7; data_b = 16'hFFFF; raddr_b = 3'd7;
    tick();
    op_b = 2'd2;
    tick();
    op_b = 2'd0;
    check("b_inc_q",     32'(q_b),     32'h0000);
    check("b_inc_carry", 32'(carry_b), 32'd1);
    check("b_inc_zero",  32'(zero_b),  32'd1);
    outctrl_b = 1'b0;
    #1 check("b_bus_rel", 32'(bus_b), 32'hFFFF);
    tick();
    op_b = 2'd3; sin_b = 1'b1; waddr_b = 3'd7;
    tick();
    op_b = 2'd0;
    check("b_shift_q", 32'(q_b), 32'h0001);
    outctrl_b = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
